// File: rtl/minhash_pkg.sv
// minhash_pkg: shared constants, FSM state type and saturating counter helper for the MinHash sketch accumulator
package minhash_pkg;
  localparam int HASHER_DATA_BITS = 32;
  localparam logic [HASHER_DATA_BITS-1:0] SIG_MAX = '1;
  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned bits);
    logic [32:0] m;
    m = (33'(1) << bits) - 33'(1);
    return (33'(v) >= m) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/minhash_lane_min.sv
// minhash_lane_min: one lane's running unsigned minimum; ports clk, rst, clear (load all-ones, wins over en), en (fold sig_in), sig_in, acc_out
module minhash_lane_min #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] sig_in,
  output logic [W-1:0] acc_out
);
  logic [W-1:0] r_acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_acc <= '1;
    else if (clear) r_acc <= '1;
    else if (en && sig_in < r_acc) r_acc <= sig_in;
  assign acc_out = r_acc;
endmodule

// File: rtl/minhash_sketch_accum.sv
// minhash_sketch_accum: per-lane running minimum over a sequence; ports sig_* (input beats, valid/ready/last), out_* (held sketch + saturating k-mer count, valid/ready)
module minhash_sketch_accum
  import minhash_pkg::*;
#(
  parameter int HASHER_DATA_BITS = minhash_pkg::HASHER_DATA_BITS,
  parameter int NUM_HASHES       = 4,
  parameter int COUNT_BITS       = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   sig_valid,
  output logic                                   sig_ready,
  input  logic [NUM_HASHES*HASHER_DATA_BITS-1:0] sig_data,
  input  logic                                   sig_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_HASHES*HASHER_DATA_BITS-1:0] out_sketch,
  output logic [COUNT_BITS-1:0]                  out_count
);
  localparam int W = HASHER_DATA_BITS;
  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_accept;
  logic [COUNT_BITS-1:0]       r_cnt;
  logic [COUNT_BITS-1:0]       w_cnt_base;
  logic [COUNT_BITS-1:0]       w_cnt_inc;
  logic [NUM_HASHES*W-1:0]     w_min;
  logic                        r_out_valid;
  logic [NUM_HASHES*W-1:0]     r_out_sketch;
  logic [COUNT_BITS-1:0]       r_out_count;
  assign sig_ready = ~r_out_valid | out_ready;
  assign w_accept  = sig_valid & sig_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  always_comb w_state_nxt = !w_accept ? r_state : (sig_last ? ST_IDLE : ST_ACCUM);
  always_comb w_cnt_base = (r_state == ST_ACCUM) ? r_cnt : '0;
  assign w_cnt_inc = COUNT_BITS'(sat_inc(32'(w_cnt_base), COUNT_BITS));
  genvar i;
  generate
    for (i = 0; i < NUM_HASHES; i++) begin : g_lane
      logic [W-1:0] w_acc;
      logic [W-1:0] w_sig;
      assign w_sig = sig_data[i*W +: W];
      minhash_lane_min #(.W(W)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_accept & sig_last),
        .en     (w_accept & ~sig_last),
        .sig_in (w_sig),
        .acc_out(w_acc)
      );
      // the last beat's own signatures must land in the emitted sketch
      assign w_min[i*W +: W] = (w_sig < w_acc) ? w_sig : w_acc;
    end
  endgenerate
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (w_accept) r_cnt <= sig_last ? '0 : w_cnt_inc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_sketch <= '1;
      r_out_count  <= '0;
    end else if (w_accept && sig_last) begin
      r_out_valid  <= 1'b1;
      r_out_sketch <= w_min;
      r_out_count  <= w_cnt_inc;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  assign out_valid  = r_out_valid;
  assign out_sketch = r_out_sketch;
  assign out_count  = r_out_count;
endmodule

// File: tb/tb_minhash_sketch_accum.sv
// tb_minhash_sketch_accum: scoreboard-driven bench for minhash_sketch_accum plus a narrow-counter saturation instance
module tb_minhash_sketch_accum;
  localparam int W = 32;
  localparam int N = 4;
  typedef struct packed {
    logic [N*W-1:0] sk;
    logic [15:0]    cnt;
  } exp_t;
  logic           clk = 0;
  logic           rst = 1;
  logic           sig_valid = 0;
  logic           sig_ready;
  logic [N*W-1:0] sig_data = '0;
  logic           sig_last = 0;
  logic           out_valid;
  logic           out_ready = 1;
  logic [N*W-1:0] out_sketch;
  logic [15:0]    out_count;
  logic           s_valid = 0;
  logic           s_ready;
  logic [N*W-1:0] s_data = '0;
  logic           s_last = 0;
  logic           s_out_valid;
  logic [N*W-1:0] s_out_sketch;
  logic [1:0]     s_out_count;
  int             checks = 0;
  int             errors = 0;
  exp_t           q[$];
  exp_t           last_exp;
  logic [W-1:0]   m_acc[N];
  int             m_cnt = 0;
  logic           bp_done;
  always #5 clk = ~clk;
  minhash_sketch_accum #(.HASHER_DATA_BITS(W), .NUM_HASHES(N), .COUNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_data(sig_data),
    .sig_last(sig_last), .out_valid(out_valid), .out_ready(out_ready), .out_sketch(out_sketch),
    .out_count(out_count)
  );
  minhash_sketch_accum #(.HASHER_DATA_BITS(W), .NUM_HASHES(N), .COUNT_BITS(2)) u_sat (
    .clk(clk), .rst(rst), .sig_valid(s_valid), .sig_ready(s_ready), .sig_data(s_data),
    .sig_last(s_last), .out_valid(s_out_valid), .out_ready(1'b1), .out_sketch(s_out_sketch),
    .out_count(s_out_count)
  );
  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction
  task automatic model_reset();
    for (int k = 0; k < N; k++) m_acc[k] = '1;
    m_cnt = 0;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected got sketch=%h count=%0d, none expected", out_sketch, out_count);
      end else begin
        e = q.pop_front();
        if (out_sketch !== e.sk || out_count !== e.cnt) begin
          errors++;
          $display("FAIL scoreboard got sketch=%h count=%0d want sketch=%h count=%0d", out_sketch, out_count, e.sk, e.cnt);
        end
      end
    end
  end
  // called at posedge+1; returns at posedge+1 after the beat was accepted
  task automatic send(input logic [N*W-1:0] d, input logic l);
    int t = 0;
    exp_t e;
    logic [W-1:0] v;
    sig_valid = 1; sig_data = d; sig_last = l;
    @(negedge clk);
    while (!sig_ready && t < 200) begin @(negedge clk); t++; end
    if (!sig_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout sig_ready=%b want 1", sig_ready);
    end else begin
      for (int k = 0; k < N; k++) begin
        v = d[k*W +: W];
        if (v < m_acc[k]) m_acc[k] = v;
      end
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (l) begin
        e.sk = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
        e.cnt = 16'(m_cnt);
        q.push_back(e);
        last_exp = e;
        model_reset();
      end
    end
    @(posedge clk); #1;
    sig_valid = 0; sig_last = 0;
  endtask
  task automatic test_reset();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (sig_ready !== 1'b1 || out_valid !== 1'b0 || out_sketch !== {N*W{1'b1}} || out_count !== 16'd0) begin
      errors++;
      $display("FAIL reset got ready=%b valid=%b sketch=%h count=%0d want 1 0 all-ones 0", sig_ready, out_valid, out_sketch, out_count);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_seq3();
    out_ready = 1;
    send(pack4(32'h50, 32'h7, 32'h9, 32'hFFFFFFFF), 0);
    send(pack4(32'h10, 32'h8, 32'h3, 32'h80000000), 0);
    send(pack4(32'h30, 32'h6, 32'hA, 32'h7FFFFFFF), 1);
    checks++;
    if (out_valid !== 1'b1 || out_sketch[0 +: W] !== 32'h10 || out_sketch[3*W +: W] !== 32'h7FFFFFFF || out_count !== 16'd3) begin
      errors++;
      $display("FAIL seq3 got valid=%b lane0=%h lane3=%h count=%0d want 1 10 7fffffff 3", out_valid, out_sketch[0 +: W], out_sketch[3*W +: W], out_count);
    end
  endtask
  task automatic test_single();
    send(pack4(32'd1, 32'd2, 32'd3, 32'd4), 1);
    checks++;
    if (out_valid !== 1'b1 || out_sketch !== pack4(32'd1, 32'd2, 32'd3, 32'd4) || out_count !== 16'd1) begin
      errors++;
      $display("FAIL single got valid=%b sketch=%h count=%0d want 1 %h 1", out_valid, out_sketch, out_count, pack4(32'd1, 32'd2, 32'd3, 32'd4));
    end
    send(pack4(32'h500, 32'h600, 32'h700, 32'h800), 0);
    send(pack4(32'h900, 32'h400, 32'hA00, 32'h300), 1);
    checks++;
    if (out_sketch !== pack4(32'h500, 32'h400, 32'h700, 32'h300) || out_count !== 16'd2) begin
      errors++;
      $display("FAIL no_pollution got sketch=%h count=%0d want %h 2", out_sketch, out_count, pack4(32'h500, 32'h400, 32'h700, 32'h300));
    end
  endtask
  task automatic test_backpressure();
    exp_t hold;
    @(posedge clk); #1;
    out_ready = 0;
    send(pack4(32'hAA, 32'hBB, 32'hCC, 32'hDD), 1);
    hold = last_exp;
    bp_done = 0;
    fork
      begin
        for (int j = 0; j < 5; j++)
          send(pack4(32'h1000 - 32'(j * 7), 32'h2000 + 32'(j), 32'h3000 ^ 32'(j * 5), 32'h100 * 32'(j + 1)), j == 4);
        bp_done = 1;
      end
    join_none
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (sig_ready !== 1'b0 || out_valid !== 1'b1 || out_sketch !== hold.sk || out_count !== hold.cnt) begin
        errors++;
        $display("FAIL backpressure_hold got ready=%b valid=%b sketch=%h count=%0d want 0 1 %h %0d", sig_ready, out_valid, out_sketch, out_count, hold.sk, hold.cnt);
      end
    end
    @(posedge clk); #1;
    out_ready = 1;
    for (int c = 0; c < 100 && !bp_done; c++) @(posedge clk);
    checks++;
    if (bp_done !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_resume done=%b want 1", bp_done);
    end
    #1;
  endtask
  task automatic test_back_to_back();
    out_ready = 1;
    for (int j = 0; j < 8; j++) begin
      send(pack4($urandom, $urandom, $urandom, $urandom), 1);
      checks++;
      if (out_valid !== 1'b1 || out_count !== 16'd1) begin
        errors++;
        $display("FAIL back_to_back beat %0d got valid=%b count=%0d want 1 1", j, out_valid, out_count);
      end
    end
  endtask
  task automatic test_reset_mid();
    out_ready = 1;
    send(pack4(32'h1, 32'h1, 32'h1, 32'h1), 0);
    send(pack4(32'h2, 32'h2, 32'h2, 32'h2), 0);
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sketch !== {N*W{1'b1}} || out_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_async got valid=%b sketch=%h count=%0d want 0 all-ones 0", out_valid, out_sketch, out_count);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    send(pack4(32'h40, 32'h50, 32'h60, 32'h70), 0);
    send(pack4(32'h45, 32'h35, 32'h65, 32'h75), 1);
    checks++;
    if (out_sketch !== pack4(32'h40, 32'h35, 32'h60, 32'h70) || out_count !== 16'd2) begin
      errors++;
      $display("FAIL reset_restart got sketch=%h count=%0d want %h 2", out_sketch, out_count, pack4(32'h40, 32'h35, 32'h60, 32'h70));
    end
  endtask
  task automatic test_saturation();
    logic [N*W-1:0] want;
    for (int j = 0; j < 6; j++) begin
      s_valid = 1;
      s_last = (j == 5);
      s_data = pack4(32'(1000 - 10 * j), 32'(1001 - 10 * j), 32'(1002 - 10 * j), 32'(1003 - 10 * j));
      @(posedge clk); #1;
    end
    s_valid = 0; s_last = 0;
    want = pack4(32'd950, 32'd951, 32'd952, 32'd953);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_count !== 2'd3 || s_out_sketch !== want) begin
      errors++;
      $display("FAIL saturation got valid=%b count=%0d sketch=%h want 1 3 %h", s_out_valid, s_out_count, s_out_sketch, want);
    end
  endtask
  initial begin
    test_reset();
    test_seq3();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/minhash_sketch_accum.md
# minhash_sketch_accum

Downstream consumer of the murmur hash lanes in the MinHash datapath. Each accepted beat carries NUM_HASHES 32-bit signatures of one k-mer, one per seed. The block keeps a running unsigned minimum per lane across a sequence. On the sequence's last beat it transfers the finished sketch, plus a k-mer count, to a held output register behind a valid/ready handshake.

## Interface
- HASHER_DATA_BITS, 32, signature width per lane
- NUM_HASHES, 4, sketch size (parallel hash lanes, ≥1)
- COUNT_BITS, 16, width of k-mer counter (saturating)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- sig_valid  in  1  beat offered
- sig_ready  out  1  beat accepted when sig_valid & sig_ready
- sig_data  in  NUM_HASHES*HASHER_DATA_BITS  lane i at bits [i*W +: W]
- sig_last  in  1  beat is last k-mer of sequence
- out_valid  out  1  sketch available
- out_ready  in  1  sketch consumed when out_valid & out_ready
- out_sketch  out  NUM_HASHES*HASHER_DATA_BITS  per-lane minima, same packing
- out_count  out  COUNT_BITS  k-mers in sequence, saturated at all-ones

## Operation
- One clock; reset is asynchronous and active-high.
- Accumulator acc[i] per lane, reset value all-ones (SIG_MAX). Counter cnt resets to 0.
- State machine, two states:
  - IDLE: no beat accepted since reset or since the last sig_last.
  - ACCUM: at least one beat accepted.
  - IDLE→ACCUM on an accepted beat with sig_last=0.
  - ACCUM→IDLE on an accepted beat with sig_last=1.
  - An accepted sig_last beat in IDLE (single-k-mer sequence) stays IDLE.
- Accepted beat, not last:
  - acc[i] ← min_unsigned(acc[i], sig_data lane i).
  - cnt ← cnt+1, saturating at 2^COUNT_BITS−1.
  - Ties keep acc[i]; observable value is identical.
- Accepted beat, last:
  - out_sketch[i] ← min_unsigned(acc[i], lane i).
  - out_count ← sat(cnt+1).
  - out_valid ← 1.
  - acc[i] ← SIG_MAX and cnt ← 0 in the same cycle.
- Output handshake:
  - out_sketch/out_count are held stable while out_valid & !out_ready.
  - out_valid clears on the handshake unless a new last beat is accepted that same cycle, in which case it stays 1 and the data updates.
- sig_ready = !out_valid | out_ready (combinational from out_ready).
  - All input stalls while a sketch is pending and unconsumed.
  - No input beat is ever dropped.
- Reset mid-sequence: acc, cnt, state, out_valid all cleared; the partial sequence is discarded.
- Reset values: sig_ready=1, out_valid=0, out_sketch=all-ones, out_count=0.

## Timing
- Throughput: one beat per cycle when not stalled.
- Latency: out_valid rises the cycle after the last beat is accepted. The sketch includes that beat's signatures.
- Back-to-back sequences: a single-beat sequence on every cycle with out_ready=1 gives out_valid continuously high, with a new sketch each cycle.
- Simultaneous last-beat accept and output handshake: the new sketch replaces the old with no bubble.
- sig_data/sig_last are sampled only on the handshake. Values while sig_valid=0 are ignored.
- No combinational path from sig_* to out_*. The only combinational path is out_ready→sig_ready.

## Structure
- Package minhash_pkg holds:
  - HASHER_DATA_BITS default constant
  - SIG_MAX = all-ones
  - state enum {ST_IDLE, ST_ACCUM}
  - sat_inc function for the counter
- Sub-module minhash_lane_min, generated NUM_HASHES times:
  - ports clk, rst, clear, en, sig_in → acc_out
  - clear loads SIG_MAX, with priority over en
  - top-level combinational min feeds out_sketch capture
- Top: FSM, counter, output register, handshake logic.

## Test plan
- Reset then idle (NUM_HASHES=4):
  - sig_ready=1, out_valid=0, out_sketch=all 0xFFFFFFFF, out_count=0.
- Sequence of 3 beats with lane0 = 0x50, 0x10, 0x30 and lane3 = 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF, out_ready=1:
  - one cycle after the last beat: out_valid=1, lane0=0x10, lane3=0x7FFFFFFF, out_count=3.
- Single-beat sequence (sig_last=1 first beat), lane values 1,2,3,4:
  - out_sketch=1,2,3,4 and out_count=1.
  - Next sequence starts from SIG_MAX: not polluted by the previous minima.
- Backpressure: hold out_ready=0 after a sketch is emitted and offer 5 more beats:
  - sig_ready=0 and out_* stable throughout.
  - Raise out_ready: beats resume in the next handshake cycle, none lost.
  - Second sketch equals the reference-model minima.
- Continuous single-beat sequences with out_ready=1 for 8 cycles:
  - out_valid stays high and a new sketch arrives each cycle, in order.
- Assert rst for 1 cycle after 2 beats of a sequence:
  - out_valid=0 immediately (async).
  - The following 2-beat sequence reports out_count=2 and minima of those 2 beats only.
- Additional check with COUNT_BITS=2 and a 6-beat sequence:
  - out_count=3 (saturated).
